// File: rtl/gas_detector_pkg.sv
// -----------------------------------------------------------------------------
// gas_detector_pkg
// Shared definitions for the gas detector array:
//   - ch_state_t   : per-channel serial receive FSM state
//   - LVL_*        : 3-bit thermometer-style level codes driven on dout
//   - HC_W         : width of the per-channel high-frame counter (PERSIST <= 15)
//   - frame_len()  : total serial frame length (start + data + stop)
//   - bit_cnt_w()  : width of the data-bit counter for a given sample width
// -----------------------------------------------------------------------------
package gas_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } ch_state_t;

    localparam logic [2:0] LVL_SAFE = 3'b000;
    localparam logic [2:0] LVL_LOW  = 3'b001;
    localparam logic [2:0] LVL_MED  = 3'b011;
    localparam logic [2:0] LVL_HIGH = 3'b111;

    localparam int HC_W = 4;

    // One start bit, data_w sample bits, one stop bit.
    function automatic int frame_len(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int bit_cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/gas_channel.sv
// -----------------------------------------------------------------------------
// gas_channel
// One serial sensor channel: receives a frame (start=1, DATA_W bits MSB first,
// stop=0), classifies the sample against three thresholds and tracks a
// persistence counter that drives the channel alarm.
//
// Optional feature: GAS_DET_ALARM_LATCH_EN -- when defined the alarm latches
// until i_clr is seen at a clock edge; otherwise i_clr is ignored and the alarm
// follows the hysteresis rule (cleared by a frame below TH_MED).
//
// Ports:
//   i_clk         rising-edge clock
//   i_arst_n      asynchronous active-low reset
//   i_din         serial sensor line, one bit per clock
//   i_clr         alarm clear (latched build only)
//   o_level       level code of the last accepted frame
//   o_frame_valid one-cycle pulse per accepted frame
//   o_frame_err   one-cycle pulse per bad stop bit
//   o_alarm       registered alarm
//   o_alarm_nxt   next-state of the alarm, used by the top for any_alarm
//   o_state       debug view of the receive FSM state
// -----------------------------------------------------------------------------
module gas_channel
    import gas_detector_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TH_LOW  = 64,
    parameter int TH_MED  = 128,
    parameter int TH_HIGH = 192,
    parameter int PERSIST = 3
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_din,
    input  logic       i_clr,
    output logic [2:0] o_level,
    output logic       o_frame_valid,
    output logic       o_frame_err,
    output logic       o_alarm,
    output logic       o_alarm_nxt,
    output logic [1:0] o_state
);

    localparam int                CNT_W     = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [HC_W-1:0]   HC_MAX    = HC_W'(PERSIST);
    localparam logic [DATA_W-1:0] TH_LOW_V  = DATA_W'(TH_LOW);
    localparam logic [DATA_W-1:0] TH_MED_V  = DATA_W'(TH_MED);
    localparam logic [DATA_W-1:0] TH_HIGH_V = DATA_W'(TH_HIGH);

    ch_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [HC_W-1:0]   r_hc;
    logic [2:0]        r_level;
    logic              r_frame_valid;
    logic              r_frame_err;
    logic              r_alarm;

    logic              w_accept;
    logic              w_reject;
    logic              w_is_high;
    logic              w_ge_med;
    logic              w_ge_low;
    logic [2:0]        w_level;
    logic [HC_W-1:0]   w_hc_frame;
    logic              w_raise;
    logic              w_alarm_nxt;
    logic [HC_W-1:0]   w_hc_nxt;

    // While in ST_STOP, r_shift holds the complete sample.
    always_comb begin
        w_accept  = (r_state == ST_STOP) && !i_din;
        w_reject  = (r_state == ST_STOP) &&  i_din;
        w_is_high = (r_shift >= TH_HIGH_V);
        w_ge_med  = (r_shift >= TH_MED_V);
        w_ge_low  = (r_shift >= TH_LOW_V);

        if (w_is_high)     w_level = LVL_HIGH;
        else if (w_ge_med) w_level = LVL_MED;
        else if (w_ge_low) w_level = LVL_LOW;
        else               w_level = LVL_SAFE;

        // High-count after an accepted frame: saturating increment or clear.
        if (!w_is_high)          w_hc_frame = '0;
        else if (r_hc >= HC_MAX) w_hc_frame = HC_MAX;
        else                     w_hc_frame = r_hc + 1'b1;

        w_raise = w_accept && w_is_high && (w_hc_frame == HC_MAX);

`ifdef GAS_DET_ALARM_LATCH_EN
        // A raising frame wins over a simultaneous clear.
        w_alarm_nxt = w_raise || (r_alarm && !i_clr);
        if (w_raise)       w_hc_nxt = w_hc_frame;
        else if (i_clr)    w_hc_nxt = '0;
        else if (w_accept) w_hc_nxt = w_hc_frame;
        else               w_hc_nxt = r_hc;
`else
        // MED frames hold the alarm; only a frame below TH_MED drops it.
        if (w_raise)                    w_alarm_nxt = 1'b1;
        else if (w_accept && !w_ge_med) w_alarm_nxt = 1'b0;
        else                            w_alarm_nxt = r_alarm;
        w_hc_nxt = w_accept ? w_hc_frame : r_hc;
`endif
    end

`ifndef GAS_DET_ALARM_LATCH_EN
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_hc          <= '0;
            r_level       <= LVL_SAFE;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_alarm       <= 1'b0;
        end else begin
            r_frame_valid <= w_accept;
            r_frame_err   <= w_reject;
            r_alarm       <= w_alarm_nxt;
            r_hc          <= w_hc_nxt;
            if (w_accept) begin
                r_level <= w_level;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_din) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                    end
                end
                ST_DATA: begin
                    r_shift <= {r_shift[DATA_W-2:0], i_din};
                    if (r_cnt == LAST_BIT) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level       = r_level;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_alarm       = r_alarm;
    assign o_alarm_nxt   = w_alarm_nxt;
    assign o_state       = r_state;

endmodule

// File: rtl/gas_detector_array.sv
// -----------------------------------------------------------------------------
// gas_detector_array
// NCH independent serial gas-sensor channels. Each channel decodes frames,
// reports a level code, and raises an alarm after PERSIST consecutive HIGH
// frames. any_alarm is registered from the channels' next-state alarms so it
// changes on the same edge as the alarm bits.
//
// Optional feature: GAS_DET_ALARM_LATCH_EN (latching alarms, cleared by
// clr_alarm[c]); without it clr_alarm is ignored.
//
// Ports:
//   clk          rising-edge clock
//   arst         asynchronous active-low reset
//   din          one serial line per channel
//   clr_alarm    per-channel alarm clear
//   dout         level codes, channel c at [3c+2:3c]
//   frame_valid  per-channel accepted-frame pulse
//   frame_err    per-channel framing-error pulse
//   alarm        per-channel alarm
//   any_alarm    OR of all alarms
//   dbg_state    per-channel FSM state, channel c at [2c+1:2c]
// -----------------------------------------------------------------------------
module gas_detector_array
    import gas_detector_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DATA_W  = 8,
    parameter int TH_LOW  = 64,
    parameter int TH_MED  = 128,
    parameter int TH_HIGH = 192,
    parameter int PERSIST = 3
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NCH-1:0]     din,
    input  logic [NCH-1:0]     clr_alarm,
    output logic [3*NCH-1:0]   dout,
    output logic [NCH-1:0]     frame_valid,
    output logic [NCH-1:0]     frame_err,
    output logic [NCH-1:0]     alarm,
    output logic               any_alarm,
    output logic [2*NCH-1:0]   dbg_state
);

    logic [NCH-1:0] w_alarm_nxt;
    logic           r_any_alarm;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gas_channel #(
            .DATA_W  (DATA_W),
            .TH_LOW  (TH_LOW),
            .TH_MED  (TH_MED),
            .TH_HIGH (TH_HIGH),
            .PERSIST (PERSIST)
        ) u_ch (
            .i_clk         (clk),
            .i_arst_n      (arst),
            .i_din         (din[c]),
            .i_clr         (clr_alarm[c]),
            .o_level       (dout[3*c +: 3]),
            .o_frame_valid (frame_valid[c]),
            .o_frame_err   (frame_err[c]),
            .o_alarm       (alarm[c]),
            .o_alarm_nxt   (w_alarm_nxt[c]),
            .o_state       (dbg_state[2*c +: 2])
        );
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_any_alarm <= 1'b0;
        end else begin
            r_any_alarm <= |w_alarm_nxt;
        end
    end

    assign any_alarm = r_any_alarm;

endmodule

// File: tb/tb_gas_detector_array.sv
// -----------------------------------------------------------------------------
// tb_gas_detector_array
// Directed bench for gas_detector_array (NCH=4, DATA_W=8, default thresholds).
// Expected {level, alarm, any_alarm} tuples are queued as each frame is
// driven and popped when frame_valid is observed.
// Handshake: frame_valid[c] is a one-cycle pulse; the matching dout slice and
// alarm[c] are valid in that same cycle and there is no back-pressure.
// -----------------------------------------------------------------------------
module tb_gas_detector_array;
    import gas_detector_pkg::*;

`ifdef GAS_DET_ALARM_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    localparam int NCH = 4;

    logic             clk;
    logic             arst;
    logic [NCH-1:0]   din;
    logic [NCH-1:0]   clr_alarm;
    logic [3*NCH-1:0] dout;
    logic [NCH-1:0]   frame_valid;
    logic [NCH-1:0]   frame_err;
    logic [NCH-1:0]   alarm;
    logic             any_alarm;
    logic [2*NCH-1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    logic [4:0] exp_q[$];   // {level[2:0], alarm, any_alarm}

    gas_detector_array #(
        .NCH(4), .DATA_W(8), .TH_LOW(64), .TH_MED(128), .TH_HIGH(192), .PERSIST(3)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .din         (din),
        .clr_alarm   (clr_alarm),
        .dout        (dout),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .alarm       (alarm),
        .any_alarm   (any_alarm),
        .dbg_state   (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] lvl, input logic al, input logic an);
        exp_q.push_back({lvl, al, an});
    endtask

    // Drive one frame on every channel in mask; returns #1 after the edge
    // that samples the stop bit, with the lines back at 0.
    task automatic run_frame(input logic [3:0] mask, input logic [7:0] val, input logic stop_b);
        logic [9:0] bits;
        bits = {1'b1, val, stop_b};
        for (int i = frame_len(8) - 1; i >= 0; i--) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) if (mask[c]) din[c] = bits[i];
        end
        @(posedge clk);
        #1;
        din = din & ~mask;
    endtask

    // Scoreboard: check pulses, then pop one expectation per valid channel.
    task automatic check_frame(input string tag, input logic [3:0] fv_exp, input logic [3:0] fe_exp);
        logic [4:0] e;
        chk({tag, " frame_valid"}, frame_valid, fv_exp);
        chk({tag, " frame_err"}, frame_err, fe_exp);
        for (int c = 0; c < NCH; c++) begin
            if (fv_exp[c] && frame_valid[c]) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL %s scoreboard observed=empty expected=entry", tag);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " level"}, dout[3*c +: 3], e[4:2]);
                    chk({tag, " alarm"}, alarm[c], e[1]);
                    chk({tag, " any_alarm"}, any_alarm, e[0]);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " dout"}, dout, 0);
        chk({tag, " frame_valid"}, frame_valid, 0);
        chk({tag, " frame_err"}, frame_err, 0);
        chk({tag, " alarm"}, alarm, 0);
        chk({tag, " any_alarm"}, any_alarm, 0);
        chk({tag, " dbg_state"}, dbg_state, 0);
    endtask

    initial begin
        arst      = 1'b0;
        din       = '0;
        clr_alarm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        arst = 1'b1;
        repeat (2) @(negedge clk);

        // Single HIGH frame on ch0
        push_exp(LVL_HIGH, 1'b0, 1'b0);
        run_frame(4'b0001, 8'hC8, 1'b0);
        check_frame("ch0_c8", 4'b0001, 4'b0000);
        @(posedge clk); #1;
        chk("ch0_fv_pulse_width", frame_valid, 0);

        // Persistence and hysteresis on ch1
        push_exp(LVL_HIGH, 1'b0, 1'b0);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("ch1_high1", 4'b0010, 4'b0000);
        push_exp(LVL_HIGH, 1'b0, 1'b0);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("ch1_high2", 4'b0010, 4'b0000);
        push_exp(LVL_HIGH, 1'b1, 1'b1);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("ch1_high3", 4'b0010, 4'b0000);
        push_exp(LVL_MED, 1'b1, 1'b1);
        run_frame(4'b0010, 8'h90, 1'b0);
        check_frame("ch1_med_hold", 4'b0010, 4'b0000);
        push_exp(LVL_SAFE, LATCH, LATCH);
        run_frame(4'b0010, 8'h20, 1'b0);
        check_frame("ch1_safe", 4'b0010, 4'b0000);

        // Framing error on ch2 keeps dout and high-count
        push_exp(LVL_HIGH, 1'b0, LATCH);
        run_frame(4'b0100, 8'hD0, 1'b0);
        check_frame("ch2_d0", 4'b0100, 4'b0000);
        run_frame(4'b0100, 8'h50, 1'b1);
        check_frame("ch2_bad_stop", 4'b0000, 4'b0100);
        chk("ch2_dout_hold", dout[8:6], LVL_HIGH);
        chk("ch2_alarm_hold", alarm[2], 0);
        push_exp(LVL_HIGH, 1'b0, LATCH);
        run_frame(4'b0100, 8'hC8, 1'b0);
        check_frame("ch2_high2", 4'b0100, 4'b0000);
        push_exp(LVL_HIGH, 1'b1, 1'b1);
        run_frame(4'b0100, 8'hC8, 1'b0);
        check_frame("ch2_high3", 4'b0100, 4'b0000);

        // Threshold boundaries on ch3
        push_exp(LVL_SAFE, 1'b0, 1'b1);
        run_frame(4'b1000, 8'h3F, 1'b0);
        check_frame("ch3_3f", 4'b1000, 4'b0000);
        push_exp(LVL_LOW, 1'b0, 1'b1);
        run_frame(4'b1000, 8'h40, 1'b0);
        check_frame("ch3_40", 4'b1000, 4'b0000);
        push_exp(LVL_MED, 1'b0, 1'b1);
        run_frame(4'b1000, 8'h80, 1'b0);
        check_frame("ch3_80", 4'b1000, 4'b0000);
        push_exp(LVL_HIGH, 1'b0, 1'b1);
        run_frame(4'b1000, 8'hC0, 1'b0);
        check_frame("ch3_c0", 4'b1000, 4'b0000);

`ifndef GAS_DET_ALARM_LATCH_EN
        // clr_alarm has no effect without latching
        @(negedge clk);
        clr_alarm = 4'b0100;
        @(posedge clk); #1;
        clr_alarm = '0;
        chk("clr_ignored_alarm", alarm, 4'b0100);
        chk("clr_ignored_any", any_alarm, 1);
`endif

        // Simultaneous frames on ch0 and ch1
        push_exp(LVL_LOW, 1'b0, 1'b1);
        push_exp(LVL_LOW, LATCH, 1'b1);
        run_frame(4'b0011, 8'h40, 1'b0);
        check_frame("ch01_simul", 4'b0011, 4'b0000);

        // Asynchronous reset in the middle of a ch0 frame
        @(negedge clk); din[0] = 1'b1;
        @(negedge clk); din[0] = 1'b1;
        @(negedge clk); din[0] = 1'b0;
        @(negedge clk); din[0] = 1'b1;
        @(negedge clk); din[0] = 1'b0;
        @(negedge clk);
        #2;
        arst = 1'b0;
        #1;
        check_all_zero("async_reset");
        din = '0;
        @(posedge clk); #1;
        @(negedge clk);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(LVL_MED, 1'b0, 1'b0);
        run_frame(4'b0001, 8'h80, 1'b0);
        check_frame("ch0_after_reset", 4'b0001, 4'b0000);

`ifdef GAS_DET_ALARM_LATCH_EN
        // Latched alarm survives a SAFE frame and clears on clr_alarm
        push_exp(LVL_HIGH, 1'b0, 1'b0);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("latch_high1", 4'b0010, 4'b0000);
        push_exp(LVL_HIGH, 1'b0, 1'b0);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("latch_high2", 4'b0010, 4'b0000);
        push_exp(LVL_HIGH, 1'b1, 1'b1);
        run_frame(4'b0010, 8'hC8, 1'b0);
        check_frame("latch_high3", 4'b0010, 4'b0000);
        push_exp(LVL_SAFE, 1'b1, 1'b1);
        run_frame(4'b0010, 8'h00, 1'b0);
        check_frame("latch_safe_hold", 4'b0010, 4'b0000);
        @(negedge clk);
        clr_alarm = 4'b0010;
        @(posedge clk); #1;
        clr_alarm = '0;
        chk("latch_clr_alarm", alarm[1], 0);
        chk("latch_clr_any", any_alarm, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gas_detector_array.md
GAS_DETECTOR_ARRAY -- requirements
Module: gas_detector_array

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of independent serial sensor channels (1..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning concentration sample width in bits (4..16).
REQ-003 The block SHALL have parameters TH_LOW, TH_MED and TH_HIGH, defaults 64, 128 and 192, meaning the classification thresholds; TH_LOW < TH_MED < TH_HIGH < 2**DATA_W.
REQ-004 The block SHALL have parameter PERSIST, default 3, meaning consecutive HIGH frames required to raise an alarm (1..15).
REQ-005 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-006 Port arst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port din, input, NCH bits: one serial sensor line per channel, sampled on every rising clk edge.
REQ-008 Port clr_alarm, input, NCH bits: per-channel alarm clear.
REQ-009 Port dout, output, 3*NCH bits: per-channel level code; channel c occupies bits [3c+2:3c].
REQ-010 Port frame_valid, output, NCH bits: one-cycle pulse per accepted frame.
REQ-011 Port frame_err, output, NCH bits: one-cycle pulse per framing error.
REQ-012 Port alarm, output, NCH bits: per-channel alarm; port any_alarm, output, 1 bit: OR of alarm.

Function
REQ-013 Each channel SHALL run an independent FSM IDLE -> DATA -> STOP -> IDLE, with one bit consumed per clock.
REQ-014 In IDLE, din=1 (start bit) SHALL move to DATA; din=0 SHALL keep IDLE.
REQ-015 DATA SHALL shift in exactly DATA_W bits MSB first, using a bit counter that wraps to 0 on entry to STOP.
REQ-016 In STOP, din=0 SHALL accept the frame; din=1 SHALL pulse frame_err, discard the sample and leave dout and alarm unchanged; both cases SHALL return to IDLE.
REQ-017 On the edge after the accepting STOP sample, frame_valid SHALL pulse and dout SHALL update: value >= TH_HIGH gives 3'b111, >= TH_MED gives 3'b011, >= TH_LOW gives 3'b001, otherwise 3'b000 (unsigned compare, thresholds inclusive).
REQ-018 Each channel SHALL keep a saturating high-count: +1 per accepted HIGH frame, saturating at PERSIST, and cleared by any accepted non-HIGH frame.
REQ-019 alarm SHALL assert in the same cycle as frame_valid for the frame that brings the high-count to PERSIST.
REQ-020 Without latching, alarm SHALL deassert with frame_valid on the first accepted frame with value < TH_MED; a MED frame SHALL hold alarm (hysteresis).
REQ-021 Framing-error frames SHALL neither increment nor clear the high-count.
REQ-022 Channels SHALL share no state; simultaneous events on different channels SHALL be handled independently in the same cycle.
REQ-023 any_alarm SHALL be registered, lagging alarm by 0 cycles (computed from next-state).

Reset
REQ-024 arst low SHALL immediately force all FSMs to IDLE, bit and high counters to 0, dout to all zeros, frame_valid, frame_err, alarm and any_alarm to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release, the next din=1 SHALL be treated as a start bit.

Configuration
REQ-026 With GAS_DET_ALARM_LATCH_EN defined, alarm SHALL stay set regardless of later frames until clr_alarm[c]=1 at a clock edge, which clears alarm[c] and the high-count; a clear and a raising frame in the same cycle SHALL leave alarm set.
REQ-027 Without GAS_DET_ALARM_LATCH_EN, clr_alarm SHALL be ignored and REQ-020 SHALL apply.

Structure
REQ-028 Package gas_detector_pkg SHALL hold the FSM state typedef, the level-code constants (LVL_SAFE, LVL_LOW, LVL_MED, LVL_HIGH) and the frame-length constant derivation.
REQ-029 Sub-module gas_channel SHALL implement one channel; gas_detector_array SHALL instantiate NCH copies in a generate loop and form any_alarm.

Verification (NCH=4, DATA_W=8, defaults)
REQ-030 Channel 0 frame 1,0xC8,0 -> frame_valid[0] pulse on the edge after the stop bit; dout[2:0]=3'b111; alarm[0]=0.
REQ-031 Three consecutive 0xC8 frames on ch1 -> alarm[1]=1 and any_alarm=1 with the third frame_valid; then a 0x90 frame keeps alarm set; then a 0x20 frame clears it (without the macro).
REQ-032 Ch2 frame 1,0x50,1 (bad stop bit) -> frame_err[2] pulse, no frame_valid, and dout[8:6] retains its prior value.
REQ-033 Boundary values 0x3F, 0x40, 0x80 and 0xC0 on ch3 -> 000, 001, 011 and 111 respectively.
REQ-034 arst driven low after 4 data bits of a ch0 frame -> all outputs 0 asynchronously; a clean frame after release decodes correctly.
REQ-035 With GAS_DET_ALARM_LATCH_EN, an alarm followed by a 0x00 frame on ch1 -> alarm stays 1; clr_alarm[1]=1 for one cycle -> alarm[1]=0 on the next edge.
